// File: rtl/add_share_pkg.sv
// add_share_pkg: shared types and constants for the two-requester
// add/subtract arbiter.
//   state_e  - control FSM states (IDLE, EXEC, RESP)
//   OP_ADD / OP_SUB - encoding of the per-request op bit
//   ID_W / NUM_REQ  - requester id width and requester count
//   id2oh    - requester id to one-hot response mask
package add_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int ID_W    = 1;
  localparam int NUM_REQ = 2;

  function automatic logic [NUM_REQ-1:0] id2oh(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/add_share_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant with its priority pointer.
//   clk, rst  - clock, synchronous active-high reset (prio -> 0)
//   req[1:0]  - request bits
//   advance   - a grant was taken this cycle; hand priority to the other side
//   grant     - one-hot grant (all zero when nothing requests)
module rr_arb2
  import add_share_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // prio_q names the requester that wins when both ask.
  logic prio_q;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Winner 0 hands priority to 1 and vice versa.
  always_ff @(posedge clk) begin
    if (rst)          prio_q <= 1'b0;
    else if (advance) prio_q <= grant[0];
  end

endmodule

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: one WIDTH-bit adder/subtractor shared by two requesters.
// Round-robin grant in IDLE, one compute cycle in EXEC, result held in RESP
// until the owning requester takes it.
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester operand handshake
//   req{0,1}_a/_b/_op     - operands; op 0 = a+b, 1 = a-b
//   rsp_valid/rsp_ready   - per-requester result handshake (rsp_valid one-hot)
//   rsp_sum, rsp_carry    - shared result bus; carry = no-borrow on subtract
//   busy                  - high whenever not IDLE
module add_share_arbiter
  import add_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             busy
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             op_q, carry_q;
  logic [ID_W-1:0]  owner_q;

  logic [1:0]            grant;
  logic                  req_hs, rsp_hs;
  logic [ID_W-1:0]       gid;
  logic [WIDTH:0]        add_res;
  logic [1:0][WIDTH-1:0] a_vec, b_vec;
  logic [1:0]            op_vec;

  assign a_vec  = {req1_a, req0_a};
  assign b_vec  = {req1_b, req0_b};
  assign op_vec = {req1_op, req0_op};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (req_hs),
    .grant   (grant)
  );

  // Grant only drives ready in IDLE; held off during reset so nothing can
  // handshake on an edge that is about to clear the block.
  assign req_ready = (state_q == IDLE && !rst) ? grant : 2'b00;
  assign req_hs    = |(req_valid & req_ready);
  assign gid       = ID_W'(grant[1]);

  // Non-owner rsp_ready is ignored.
  assign rsp_hs = (state_q == RESP) && rsp_ready[owner_q];

  // Subtract as a + ~b + 1 so the carry out doubles as "no borrow".
  assign add_res = {1'b0, a_q} + {1'b0, (op_q == OP_SUB) ? ~b_q : b_q}
                 + (WIDTH+1)'(op_q == OP_SUB);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      owner_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        a_q     <= a_vec[gid];
        b_q     <= b_vec[gid];
        op_q    <= op_vec[gid];
        owner_q <= gid;
      end
      if (state_q == EXEC) {carry_q, sum_q} <= add_res;
    end
  end

  assign rsp_valid = (state_q == RESP) ? id2oh(owner_q) : 2'b00;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_share_arbiter.sv
module tb_add_share_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp_sum;
  logic         req0_op, req1_op, rsp_carry, busy;

  always #5 clk = ~clk;

  add_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy)
  );

  int n_chk = 0, n_fail = 0;
  int cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Transaction-level reference: plain integer arithmetic.
  function automatic logic [8:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic op);
    int s;
    if (!op) begin
      s = int'(a) + int'(b);
      return 9'(s);
    end
    s = int'(a) - int'(b);
    return {s >= 0, 8'(s)};
  endfunction

  function automatic logic [1:0] grant_m(input logic [1:0] v, input bit p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Model: an outstanding transaction is presented from two cycles after the
  // accepting cycle until taken; the block is free again the cycle after.
  bit         outst, own_m, prio_m;
  int         acc_n, free_from;
  logic [8:0] val_m, held_m;
  bit         acc_ev [2];
  int         grant_log[$], acc_log[$];
  int         hs_cnt = 0, obs_lat;
  logic [7:0] obs_sum;
  logic       obs_carry;
  logic [1:0] obs_rr;

  task automatic cyc();
    bit         idle;
    logic [1:0] exp_rv, exp_rr;
    @(negedge clk);
    acc_ev[0] = 0;
    acc_ev[1] = 0;
    obs_rr = req_ready;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'(2'b00));
      outst = 0; free_from = cyc_n + 1; prio_m = 0; held_m = '0;
    end else begin
      idle   = !outst && cyc_n >= free_from;
      exp_rv = (outst && cyc_n >= acc_n + 2) ? (own_m ? 2'b10 : 2'b01) : 2'b00;
      exp_rr = idle ? grant_m(req_valid, prio_m) : 2'b00;
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("busy", 32'(busy), 32'(!idle));
      if (exp_rv != 2'b00) held_m = val_m;
      chk("rsp_sum", 32'(rsp_sum), 32'(held_m[7:0]));
      chk("rsp_carry", 32'(rsp_carry), 32'(held_m[8]));
      if (|(req_valid & exp_rr)) begin
        own_m  = exp_rr[1];
        outst  = 1;
        acc_n  = cyc_n;
        prio_m = !own_m;
        val_m  = own_m ? ref_op(req1_a, req1_b, req1_op) : ref_op(req0_a, req0_b, req0_op);
        acc_ev[own_m] = 1;
        grant_log.push_back(int'(own_m));
        acc_log.push_back(cyc_n);
      end
      if (|(exp_rv & rsp_ready)) begin
        outst = 0; free_from = cyc_n + 1;
        obs_sum = rsp_sum; obs_carry = rsp_carry; obs_lat = cyc_n - acc_n;
        hs_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic op);
    if (i == 0) begin req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_a = a; req1_b = b; req1_op = op; end
  endtask

  task automatic drain(input string tag);
    int h0;
    h0 = hs_cnt;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int k = 0; k < 10 && outst; k++) cyc();
    if (h0 != hs_cnt || !outst) cyc();
    chk({tag, "_drain"}, 32'(busy), 32'(0));
  endtask

  task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic op,
                       input logic [7:0] es, input logic ec, input string tag);
    int h0;
    set_ops(i, a, b, op);
    req_valid = 2'b00;
    req_valid[i] = 1'b1;
    rsp_ready = 2'b11;
    for (int k = 0; k < 10 && !acc_ev[i]; k++) cyc();
    chk({tag, "_accept"}, 32'(acc_ev[i]), 32'(1));
    req_valid = 2'b00;
    h0 = hs_cnt;
    for (int k = 0; k < 10 && hs_cnt == h0; k++) cyc();
    chk({tag, "_done"}, 32'(hs_cnt), 32'(h0 + 1));
    chk({tag, "_sum"}, 32'(obs_sum), 32'(es));
    chk({tag, "_carry"}, 32'(obs_carry), 32'(ec));
    chk({tag, "_latency"}, 32'(obs_lat), 32'(2));
  endtask

  initial begin
    int st;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    set_ops(0, 8'h00, 8'h00, 1'b0);
    set_ops(1, 8'h00, 8'h00, 1'b0);
    #1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));

    do_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "add");
    do_op(1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, "sub_borrow");
    do_op(1, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, "sub_noborrow");
    do_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap_add");
    do_op(1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, "wrap_sub");

    // Contention: both always valid, results always taken.
    st = grant_log.size();
    set_ops(0, 8'($urandom), 8'($urandom), 1'($urandom));
    set_ops(1, 8'($urandom), 8'($urandom), 1'($urandom));
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 60 && grant_log.size() < st + 8; k++) begin
      cyc();
      for (int i = 0; i < 2; i++)
        if (acc_ev[i]) set_ops(i, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    chk("cont_count", 32'(grant_log.size()), 32'(st + 8));
    for (int k = 0; k < 8 && st + k < grant_log.size(); k++) begin
      chk("cont_order", 32'(grant_log[st+k]), 32'(k % 2));
      if (k > 0) chk("cont_gap", 32'(acc_log[st+k] - acc_log[st+k-1]), 32'(3));
    end
    drain("cont");

    // Backpressure: owner 0 withholds rsp_ready, non-owner offers it.
    set_ops(0, 8'h9C, 8'h71, 1'b0);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    for (int k = 0; k < 10 && !acc_ev[0]; k++) cyc();
    chk("bp_accept", 32'(acc_ev[0]), 32'(1));
    req_valid = 2'b00;
    cyc();
    set_ops(1, 8'h33, 8'h44, 1'b1);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    repeat (5) begin
      cyc();
      chk("bp_held_valid", 32'(rsp_valid), 32'(2'b01));
      chk("bp_held_sum", 32'(rsp_sum), 32'(8'h0D));
    end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b11;
    for (int k = 0; k < 10 && !acc_ev[1]; k++) cyc();
    chk("bp_next_accept", 32'(acc_ev[1]), 32'(1));
    drain("bp");

    // Reset while EXEC: result dropped, prio back to requester 0.
    set_ops(0, 8'h21, 8'h10, 1'b0);
    req_valid = 2'b01;
    for (int k = 0; k < 10 && !acc_ev[0]; k++) cyc();
    req_valid = 2'b00;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_ops(0, 8'h01, 8'h02, 1'b0);
    set_ops(1, 8'h03, 8'h04, 1'b0);
    req_valid = 2'b11;
    cyc();
    chk("rst_mid_grant", 32'(obs_rr), 32'(2'b01));
    req_valid = 2'b10;
    for (int k = 0; k < 10 && !acc_ev[1]; k++) cyc();
    drain("rst_mid");

    // Random traffic, including dropped requests and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (acc_ev[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_ops(i, 8'($urandom), 8'($urandom), 1'($urandom));
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = 2'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
